ysyx_23060061_wb_arbiter: RTL

//   Writeback-side driver of the register file write port (wen/waddr/wdata).

---
 rtl/ysyx_23060061_wb_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ysyx_23060061_wb_arbiter.sv
// Writeback arbiter: one-entry buffers for EXU and LSU results, round-robin grant, registered RF write port.
// Optional combinational writeback bypass ports are enabled with `define WB_BYPASS_EN.
module ysyx_23060061_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
`ifdef WB_BYPASS_EN
    input  logic [ADDR_WIDTH-1:0] byp_raddr1,
    input  logic [ADDR_WIDTH-1:0] byp_raddr2,
    output logic                  byp_hit1,
    output logic                  byp_hit2,
    output logic [DATA_WIDTH-1:0] byp_data1,
    output logic [DATA_WIDTH-1:0] byp_data2,
`endif
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  wb_done
);

    typedef enum logic {
        SRC_EXU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    logic                  exu_buf_valid;
    logic [ADDR_WIDTH-1:0] exu_buf_rd;
    logic [DATA_WIDTH-1:0] exu_buf_data;
    logic                  lsu_buf_valid;
    logic [ADDR_WIDTH-1:0] lsu_buf_rd;
    logic [DATA_WIDTH-1:0] lsu_buf_data;

    src_e                  last_grant;
    logic                  grant_valid;
    src_e                  grant_src;
    logic [ADDR_WIDTH-1:0] grant_rd;
    logic [DATA_WIDTH-1:0] grant_data;

    logic exu_fire;
    logic lsu_fire;

    assign exu_ready = ~rst & ~exu_buf_valid;
    assign lsu_ready = ~rst & ~lsu_buf_valid;
    assign exu_fire  = exu_valid & exu_ready;
    assign lsu_fire  = lsu_valid & lsu_ready;

    // NOTE: every signal gets a default before the branches so no latch is inferred.
    always_comb begin
        grant_valid = exu_buf_valid | lsu_buf_valid;
        grant_src   = SRC_EXU;
        if (exu_buf_valid && lsu_buf_valid) begin
            // On a tie the source that did not win last time goes first.
            grant_src = (last_grant == SRC_EXU) ? SRC_LSU : SRC_EXU;
        end else if (lsu_buf_valid) begin
            grant_src = SRC_LSU;
        end
        grant_rd   = (grant_src == SRC_LSU) ? lsu_buf_rd   : exu_buf_rd;
        grant_data = (grant_src == SRC_LSU) ? lsu_buf_data : exu_buf_data;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            exu_buf_valid <= 1'b0;
            lsu_buf_valid <= 1'b0;
            last_grant    <= SRC_EXU;
            rf_wen        <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            wb_done       <= 1'b0;
        end else begin
            // A full buffer is never ready, so fill and grant of one buffer are exclusive.
            if (exu_fire) begin
                exu_buf_valid <= 1'b1;
            end else if (grant_valid && grant_src == SRC_EXU) begin
                exu_buf_valid <= 1'b0;
            end

            if (lsu_fire) begin
                lsu_buf_valid <= 1'b1;
            end else if (grant_valid && grant_src == SRC_LSU) begin
                lsu_buf_valid <= 1'b0;
            end

            if (grant_valid) begin
                last_grant <= grant_src;
                rf_wen     <= (grant_rd != '0);
                rf_waddr   <= grant_rd;
                rf_wdata   <= grant_data;
                wb_done    <= 1'b1;
            end else begin
                rf_wen  <= 1'b0;
                wb_done <= 1'b0;
            end
        end
    end

    // NOTE: payload registers are qualified by their valid bits, so they carry no reset.
    always_ff @(posedge clk) begin
        if (exu_fire) begin
            exu_buf_rd   <= exu_rd;
            exu_buf_data <= exu_data;
        end
        if (lsu_fire) begin
            lsu_buf_rd   <= lsu_rd;
            lsu_buf_data <= lsu_data;
        end
    end

`ifdef WB_BYPASS_EN
    assign byp_hit1  = rf_wen & (rf_waddr == byp_raddr1) & (byp_raddr1 != '0);
    assign byp_hit2  = rf_wen & (rf_waddr == byp_raddr2) & (byp_raddr2 != '0);
    assign byp_data1 = byp_hit1 ? rf_wdata : '0;
    assign byp_data2 = byp_hit2 ? rf_wdata : '0;
`endif

endmodule
